// File: rtl/di_term_arbiter_if.sv
// di_term_arbiter_if: host/terminal side of the shared di return-path arbiter.
//   master: drives host modes/strobes and the per-terminal claim/ready/data/status buses
//   slave : returns muxed rdy/data/status plus grant and sticky error flags
//   xfer_count/timeout_count exist only when DI_TERM_ARBITER_STATS_EN is defined
interface di_term_arbiter_if #(
   parameter int NUM_TERMS     = 4,
   parameter int DI_DATA_WIDTH = 32
);
   logic                               di_read_mode;
   logic                               di_write_mode;
   logic                               di_read;
   logic                               di_write;
   logic [NUM_TERMS-1:0]               term_en;
   logic [NUM_TERMS-1:0]               term_read_rdy;
   logic [NUM_TERMS-1:0]               term_write_rdy;
   logic [NUM_TERMS*DI_DATA_WIDTH-1:0] term_reg_datao;
   logic [NUM_TERMS*16-1:0]            term_transfer_status;
   logic                               di_read_rdy;
   logic                               di_write_rdy;
   logic [DI_DATA_WIDTH-1:0]           di_reg_datao;
   logic [15:0]                        di_transfer_status;
   logic                               grant_valid;
   logic [3:0]                         grant_idx;
   logic                               collision_err;
   logic                               timeout_err;
`ifdef DI_TERM_ARBITER_STATS_EN
   logic [31:0]                        xfer_count;
   logic [15:0]                        timeout_count;
`endif
   modport master (
      output di_read_mode, di_write_mode, di_read, di_write,
      output term_en, term_read_rdy, term_write_rdy, term_reg_datao, term_transfer_status,
      input  di_read_rdy, di_write_rdy, di_reg_datao, di_transfer_status,
      input  grant_valid, grant_idx, collision_err, timeout_err
`ifdef DI_TERM_ARBITER_STATS_EN
      , input xfer_count, timeout_count
`endif
   );
   modport slave (
      input  di_read_mode, di_write_mode, di_read, di_write,
      input  term_en, term_read_rdy, term_write_rdy, term_reg_datao, term_transfer_status,
      output di_read_rdy, di_write_rdy, di_reg_datao, di_transfer_status,
      output grant_valid, grant_idx, collision_err, timeout_err
`ifdef DI_TERM_ARBITER_STATS_EN
      , output xfer_count, timeout_count
`endif
   );
endinterface

// File: rtl/di_term_arbiter.sv
// di_term_arbiter: registered-grant arbiter for the shared di return path between terminal blocks.
//   ifclk  : clock
//   resetb : asynchronous active-low reset
//   p      : di_term_arbiter_if.slave (host modes/strobes, per-terminal buses in; muxed di_* and status out)
//   Optional DI_TERM_ARBITER_STATS_EN adds p.xfer_count (mode falling edges) and
//   p.timeout_count (saturating TIMEOUT entries).
module di_term_arbiter #(
   parameter int          NUM_TERMS       = 4,
   parameter int          DI_DATA_WIDTH   = 32,
   parameter int          TIMEOUT_CYCLES  = 1024,
   parameter logic [15:0] UNMAPPED_STATUS = 16'hAAAA,
   parameter logic [15:0] TIMEOUT_STATUS  = 16'hDEAD
) (
   input logic               ifclk,
   input logic               resetb,
   di_term_arbiter_if.slave  p
);
   typedef enum logic [1:0] {IDLE, ACTIVE, UNMAPPED, TIMEOUT} state_t;
   state_t                   state;
   logic                     mode, mode_q, rise, stall, to_hit;
   logic                     grant_valid_q, coll_q, terr_q;
   logic [3:0]               grant_q, first;
   logic [15:0]              stall_cnt;
   logic                     rrdy_g, wrdy_g;
   logic [DI_DATA_WIDTH-1:0] data_g;
   logic [15:0]              stat_g;

   assign mode   = p.di_read_mode | p.di_write_mode;
   assign rise   = mode & ~mode_q;
   assign stall  = (p.di_read & ~rrdy_g) | (p.di_write & ~wrdy_g);
   assign to_hit = (state == ACTIVE) & mode & stall & (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

   // first: lowest claiming terminal; *_g: the granted terminal's return signals
   always_comb begin
      first  = '0;
      rrdy_g = 1'b0;
      wrdy_g = 1'b0;
      data_g = '0;
      stat_g = '0;
      for (int i = NUM_TERMS - 1; i >= 0; i--)
         if (p.term_en[i]) first = 4'(i);
      for (int i = 0; i < NUM_TERMS; i++)
         if (grant_q == 4'(i)) begin
            rrdy_g = p.term_read_rdy[i];
            wrdy_g = p.term_write_rdy[i];
            data_g = p.term_reg_datao[i*DI_DATA_WIDTH +: DI_DATA_WIDTH];
            stat_g = p.term_transfer_status[i*16 +: 16];
         end
   end

   assign p.di_read_rdy        = (state == ACTIVE) ? rrdy_g : 1'b1;
   assign p.di_write_rdy       = (state == ACTIVE) ? wrdy_g : 1'b1;
   assign p.di_reg_datao       = (state == ACTIVE) ? data_g : '0;
   assign p.di_transfer_status = (state == ACTIVE) ? stat_g :
                                 (state == TIMEOUT) ? TIMEOUT_STATUS : UNMAPPED_STATUS;
   assign p.grant_valid        = grant_valid_q;
   assign p.grant_idx          = grant_q;
   assign p.collision_err      = coll_q;
   assign p.timeout_err        = terr_q;

   always_ff @(posedge ifclk or negedge resetb) begin
      if (!resetb) begin
         state         <= IDLE;
         mode_q        <= 1'b0;
         grant_valid_q <= 1'b0;
         grant_q       <= '0;
         coll_q        <= 1'b0;
         terr_q        <= 1'b0;
         stall_cnt     <= '0;
      end else begin
         mode_q <= mode;
         if (!mode) begin
            state         <= IDLE;
            grant_valid_q <= 1'b0;
            stall_cnt     <= '0;
         end else if (state == IDLE && rise) begin
            // term_en is only looked at here, so later claim changes cannot steal the grant
            state         <= (|p.term_en) ? ACTIVE : UNMAPPED;
            grant_valid_q <= |p.term_en;
            if (|p.term_en) grant_q <= first;
            if ($countones(p.term_en) > 1) coll_q <= 1'b1;
         end else if (state == ACTIVE) begin
            stall_cnt <= (stall && !to_hit) ? stall_cnt + 16'd1 : '0;
            if (to_hit) begin
               state  <= TIMEOUT;
               terr_q <= 1'b1;
            end
         end
      end
   end

`ifdef DI_TERM_ARBITER_STATS_EN
   logic [31:0] xfer_q;
   logic [15:0] tocnt_q;
   assign p.xfer_count    = xfer_q;
   assign p.timeout_count = tocnt_q;
   always_ff @(posedge ifclk or negedge resetb) begin
      if (!resetb) begin
         xfer_q  <= '0;
         tocnt_q <= '0;
      end else begin
         if (mode_q && !mode) xfer_q <= xfer_q + 32'd1;
         if (to_hit && tocnt_q != 16'hFFFF) tocnt_q <= tocnt_q + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_di_term_arbiter.sv
// tb_di_term_arbiter: directed literal checks plus randomized transactions against a behavioural model.
module tb_di_term_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic resetb = 1'b1;
   bit   chk_en = 1'b0;
   int   tests = 0;
   int   fails = 0;

   di_term_arbiter_if #(.NUM_TERMS(N), .DI_DATA_WIDTH(DW)) bus ();
   di_term_arbiter #(.NUM_TERMS(N), .DI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .ifclk(clk), .resetb(resetb), .p(bus)
   );

   always #5 clk = ~clk;

   // model: which terminal owns the current transaction (-1 none/unmapped), and whether it timed out
   int          m_owner = -1;
   int          m_stall = 0;
   bit          m_to = 1'b0, m_prev = 1'b0, m_coll = 1'b0, m_terr = 1'b0;
   int unsigned m_xfers = 0, m_tocnt = 0;
   bit          m_mode, m_stuck;

   always @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         m_owner = -1; m_stall = 0; m_to = 0; m_prev = 0; m_coll = 0; m_terr = 0;
         m_xfers = 0; m_tocnt = 0;
      end else begin
         m_mode = bus.di_read_mode | bus.di_write_mode;
         if (!m_mode) begin
            if (m_prev) m_xfers++;
            m_owner = -1; m_to = 0; m_stall = 0;
         end else if (!m_prev) begin
            m_owner = -1; m_to = 0; m_stall = 0;
            for (int i = N - 1; i >= 0; i--) if (bus.term_en[i]) m_owner = i;
            if ($countones(bus.term_en) > 1) m_coll = 1;
         end else if (m_owner >= 0 && !m_to) begin
            m_stuck = (bus.di_read && !bus.term_read_rdy[m_owner]) ||
                      (bus.di_write && !bus.term_write_rdy[m_owner]);
            m_stall = m_stuck ? m_stall + 1 : 0;
            if (m_stall == TO) begin
               m_to = 1; m_terr = 1; m_stall = 0;
               if (m_tocnt < 65535) m_tocnt++;
            end
         end
         m_prev = m_mode;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (chk_en) begin : cmp
      logic        e_r, e_w;
      logic [31:0] e_d;
      logic [15:0] e_s;
      #2;
      if (m_owner >= 0 && !m_to) begin
         e_r = bus.term_read_rdy[m_owner];
         e_w = bus.term_write_rdy[m_owner];
         e_d = bus.term_reg_datao[m_owner*DW +: DW];
         e_s = bus.term_transfer_status[m_owner*16 +: 16];
      end else begin
         e_r = 1; e_w = 1; e_d = 0;
         e_s = m_to ? 16'hDEAD : 16'hAAAA;
      end
      check("m_read_rdy", bus.di_read_rdy, e_r);
      check("m_write_rdy", bus.di_write_rdy, e_w);
      check("m_datao", bus.di_reg_datao, e_d);
      check("m_status", bus.di_transfer_status, e_s);
      check("m_grant_valid", bus.grant_valid, m_owner >= 0);
      if (m_owner >= 0) check("m_grant_idx", bus.grant_idx, m_owner);
      check("m_collision", bus.collision_err, m_coll);
      check("m_timeout_err", bus.timeout_err, m_terr);
`ifdef DI_TERM_ARBITER_STATS_EN
      check("m_xfer_count", bus.xfer_count, m_xfers);
      check("m_timeout_count", bus.timeout_count, m_tocnt);
`endif
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic end_txn();
      cyc();
      bus.di_read_mode = 0; bus.di_write_mode = 0; bus.di_read = 0; bus.di_write = 0;
      cyc();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int len, kind, gap;
      bit w;
      bus.di_read_mode = 0; bus.di_write_mode = 0; bus.di_read = 0; bus.di_write = 0;
      bus.term_en = '0; bus.term_read_rdy = '1; bus.term_write_rdy = '1;
      bus.term_reg_datao = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hA0A0_A0A0};
      bus.term_transfer_status = {16'h3003, 16'h2002, 16'h1001, 16'h0F00};
      #1 resetb = 0;
      chk_en = 1;
      repeat (2) cyc();
      #3;
      check("rst_grant_valid", bus.grant_valid, 0);
      check("rst_grant_idx", bus.grant_idx, 0);
      check("rst_collision", bus.collision_err, 0);
      check("rst_timeout", bus.timeout_err, 0);
      check("rst_status", bus.di_transfer_status, 16'hAAAA);
      check("rst_rdy", {bus.di_read_rdy, bus.di_write_rdy}, 2'b11);
      resetb = 1;

      // granted read returns terminal 1 data with no added latency
      cyc();
      bus.term_en = 4'b0010; bus.di_read_mode = 1; bus.di_read = 1;
      cyc(); #3;
      check("t1_datao", bus.di_reg_datao, 32'h1234_5678);
      check("t1_grant_idx", bus.grant_idx, 1);
      check("t1_grant_valid", bus.grant_valid, 1);
      end_txn(); #3;
      check("t1_released", bus.grant_valid, 0);

      // nobody claims the address
      bus.term_en = 4'b0000; bus.di_read_mode = 1;
      cyc(); #3;
      check("t2_status", bus.di_transfer_status, 16'hAAAA);
      check("t2_rdy", bus.di_read_rdy, 1);
      check("t2_datao", bus.di_reg_datao, 0);
      cyc(); #3;
      check("t2_status_hold", bus.di_transfer_status, 16'hAAAA);
      end_txn();

      // two claims: lowest wins, collision sticks through a clean transaction
      bus.term_en = 4'b0110; bus.di_read_mode = 1;
      cyc(); #3;
      check("t3_grant_idx", bus.grant_idx, 1);
      check("t3_collision", bus.collision_err, 1);
      end_txn();
      bus.term_en = 4'b0001; bus.di_read_mode = 1;
      cyc(); #3;
      check("t3_clean_idx", bus.grant_idx, 0);
      check("t3_collision_sticky", bus.collision_err, 1);
      end_txn();

      // write stall forces completion after TO stalled cycles
      bus.term_en = 4'b0001; bus.di_write_mode = 1; bus.di_write = 1; bus.term_write_rdy = '0;
      cyc(); #3;
      check("t4_stalled", bus.di_write_rdy, 0);
      repeat (TO - 1) cyc();
      #3;
      check("t4_not_yet", bus.di_write_rdy, 0);
      check("t4_no_err_yet", bus.timeout_err, 0);
      cyc(); #3;
      check("t4_forced_rdy", bus.di_write_rdy, 1);
      check("t4_status", bus.di_transfer_status, 16'hDEAD);
      check("t4_timeout_err", bus.timeout_err, 1);
      end_txn();
      bus.term_write_rdy = '1;

      // claim change mid-transaction is ignored
      bus.term_en = 4'b0001; bus.di_read_mode = 1;
      cyc();
      bus.term_en = 4'b0100;
      repeat (3) cyc();
      #3;
      check("t5_held_idx", bus.grant_idx, 0);
      end_txn();
      bus.di_read_mode = 1;
      cyc(); #3;
      check("t5_next_idx", bus.grant_idx, 2);

      // async reset mid-transaction
      cyc(); #3;
      check("t6_pre_grant", bus.grant_valid, 1);
      resetb = 0;
      #1;
      check("t6_grant_valid", bus.grant_valid, 0);
      check("t6_status", bus.di_transfer_status, 16'hAAAA);
      check("t6_datao", bus.di_reg_datao, 0);
      check("t6_errs", {bus.collision_err, bus.timeout_err}, 2'b00);
      cyc();
      bus.di_read_mode = 0;
      resetb = 1;
      for (int t = 0; t < 3; t++) begin
         cyc();
         bus.term_en = 4'(t + 1); bus.di_read_mode = 1;
         cyc(); cyc();
         bus.di_read_mode = 0;
      end
      cyc(); #3;
`ifdef DI_TERM_ARBITER_STATS_EN
      check("t6_xfer_count", bus.xfer_count, 3);
`endif

      // randomized transactions
      cyc();
      for (int t = 0; t < 250; t++) begin
         kind = $urandom_range(0, 3);
         len  = (kind == 1) ? $urandom_range(TO + 2, 20) : $urandom_range(1, 20);
         gap  = $urandom_range(1, 3);
         w    = 1'($urandom_range(0, 1));
         bus.di_read_mode = !w || ($urandom_range(0, 7) == 0);
         bus.di_write_mode = w;
         for (int c = 0; c < len; c++) begin
            bus.term_en = 4'($urandom_range(0, 15));
            bus.term_reg_datao = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.term_transfer_status = {$urandom(), $urandom()};
            bus.term_read_rdy = (kind == 1) ? 4'b0 : 4'($urandom_range(0, 15));
            bus.term_write_rdy = (kind == 1) ? 4'b0 : 4'($urandom_range(0, 15));
            bus.di_read = !w && (kind == 1 || $urandom_range(0, 1) == 1);
            bus.di_write = w && (kind == 1 || $urandom_range(0, 1) == 1);
            cyc();
         end
         bus.di_read_mode = 0; bus.di_write_mode = 0; bus.di_read = 0; bus.di_write = 0;
         repeat (gap) cyc();
      end
      repeat (3) cyc();
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
